// File: rtl/array_init_mem_if.sv
// rtl/array_init_mem_if.sv - port bundle for the self-initialising memory array
interface array_init_mem_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 200
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              init_start;
    logic [1:0]        init_mode;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              dump_start;
    logic [ADDR_W:0]   dump_count;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [WIDTH-1:0]  dump_data;
    logic              dump_done;

    modport master (
        output init_start, init_mode, wr_en, wr_addr, wr_data,
               rd_en, rd_addr, dump_start, dump_count,
        input  busy, rd_data, rd_valid, dump_valid, dump_addr, dump_data, dump_done
    );

    modport slave (
        input  init_start, init_mode, wr_en, wr_addr, wr_data,
               rd_en, rd_addr, dump_start, dump_count,
        output busy, rd_data, rd_valid, dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/array_init_mem.sv
// rtl/array_init_mem.sv - memory array with fill sequencer, registered read port and dump stream
module array_init_mem #(
    parameter int          WIDTH         = 32,
    parameter int          DEPTH         = 200,
    parameter logic [31:0] FILL_VALUE    = 32'hff223344,
    parameter logic [31:0] PATTERN_BASE  = 32'hff12,
    parameter int          PATTERN_SHIFT = 16,
    parameter int          RESET_MODE    = 1
) (
    input logic            clk,
    input logic            rst,
    array_init_mem_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(DEPTH - 1);
    localparam logic [WIDTH-1:0] FILL_W     = WIDTH'(FILL_VALUE);
    localparam logic [WIDTH-1:0] PATTERN_HI = WIDTH'(PATTERN_BASE) << PATTERN_SHIFT;

    typedef enum logic [1:0] {IDLE, FILL, DUMP} state_t;

    // Modes other than 0/1 mean "leave contents alone" after reset.
    localparam state_t     RESET_STATE  = (RESET_MODE == 0 || RESET_MODE == 1) ? FILL : IDLE;
    localparam logic [1:0] RESET_MODE_C = 2'(RESET_MODE);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] dump_n;

    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              rd_accept;
    logic              dump_issue;
    logic              dump_last;

    logic [WIDTH-1:0]  rd_data_q;
    logic              rd_valid_q;
    logic              dump_valid_q;
    logic [ADDR_W-1:0] dump_addr_q;
    logic [WIDTH-1:0]  dump_data_q;
    logic              dump_done_q;

    logic             init_req;
    logic             wr_in_range;
    logic             rd_in_range;
    logic [CNT_W-1:0] dump_clip;

    assign init_req    = bus.init_start && (bus.init_mode == 2'd0 || bus.init_mode == 2'd1);
    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_C;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_C;
    assign dump_clip   = (bus.dump_count > DEPTH_C) ? DEPTH_C : bus.dump_count;

    // The done pulse is raised while issuing the last read (or at once for N = 0),
    // so it lines up with the final registered beat.
    assign dump_last = (state == DUMP) && !dump_done_q && ((cnt + CNT_W'(1)) >= dump_n);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a valid fill request beats a simultaneous dump request
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (init_req) begin
                    state_nxt = FILL;
                end else if (bus.dump_start) begin
                    state_nxt = DUMP;
                end
            end
            FILL: begin
                if (cnt == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            DUMP: begin
                if (dump_done_q) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state outputs: who owns the write port, whether reads/dump beats are issued
    always_comb begin
        busy       = (state != IDLE);
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = bus.wr_data;
        rd_accept  = 1'b0;
        dump_issue = 1'b0;
        case (state)
            IDLE: begin
                mem_we    = bus.wr_en && wr_in_range;
                rd_accept = bus.rd_en;
            end
            FILL: begin
                mem_we    = 1'b1;
                mem_waddr = cnt[ADDR_W-1:0];
                mem_wdata = (mode_q == 2'd0) ? FILL_W : (PATTERN_HI | WIDTH'(cnt[ADDR_W-1:0]));
            end
            DUMP: begin
                dump_issue = (cnt < dump_n);
            end
            default: ;
        endcase
    end

    // Sequencer index, latched fill mode and clipped dump length
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mode_q <= RESET_MODE_C;
            dump_n <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (init_req) begin
                        mode_q <= bus.init_mode;
                    end else if (bus.dump_start) begin
                        dump_n <= dump_clip;
                    end
                end
                FILL: cnt <= cnt + CNT_W'(1);
                DUMP: begin
                    if (dump_issue) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Array storage; contents survive reset, writes are suppressed during it
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read and dump outputs; reads see the pre-write contents (read-first)
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= rd_in_range ? mem[bus.rd_addr] : '0;
            end
            dump_valid_q <= dump_issue;
            if (dump_issue) begin
                dump_data_q <= mem[cnt[ADDR_W-1:0]];
                dump_addr_q <= cnt[ADDR_W-1:0];
            end
            dump_done_q <= dump_last;
        end
    end

    assign bus.busy       = busy;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_done  = dump_done_q;
endmodule

// File: tb/tb_array_init_mem.sv
// tb/tb_array_init_mem.sv - self-checking bench for array_init_mem
module tb_array_init_mem;
    localparam int WIDTH = 32;
    localparam int DEPTH = 200;

    logic clk = 1'b0;
    logic rst;

    array_init_mem_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    array_init_mem #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FILL_VALUE(32'hff223344),
        .PATTERN_BASE(32'hff12), .PATTERN_SHIFT(16), .RESET_MODE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors;
    int checks;
    bit saw_dump;
    logic [31:0] model [DEPTH];
    logic [31:0] last_rd;

    typedef struct {
        logic        wr_en;
        logic [7:0]  wr_addr;
        logic [31:0] wr_data;
        logic        rd_en;
        logic [7:0]  rd_addr;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fill_word(input int mode, input int idx);
        if (mode == 0) return 32'hff223344;
        return (32'hff12 << 16) | 32'(idx);
    endfunction

    function automatic logic [31:0] model_read(input int addr);
        if (addr >= DEPTH) return 32'h0;
        return model[addr];
    endfunction

    task automatic model_fill(input int mode);
        for (int i = 0; i < DEPTH; i++) model[i] = fill_word(mode, i);
    endtask

    task automatic model_write(input int addr, input logic [31:0] data);
        if (addr < DEPTH) model[addr] = data;
    endtask

    task automatic clear_inputs();
        bus.init_start = 1'b0;
        bus.init_mode  = 2'd0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.dump_start = 1'b0;
        bus.dump_count = '0;
    endtask

    task automatic wait_idle(input string name, input int expected);
        int n = 0;
        while (bus.busy === 1'b1 && n < expected + 20) begin
            if (bus.dump_valid === 1'b1) saw_dump = 1'b1;
            n++;
            step();
        end
        check(name, 64'(n), 64'(expected));
    endtask

    task automatic do_fill(input int mode);
        bus.init_start = 1'b1;
        bus.init_mode  = 2'(mode);
        step();
        bus.init_start = 1'b0;
        if (mode < 2) begin
            check("fill_busy_start", bus.busy, 1'b1);
            wait_idle("fill_busy_cycles", DEPTH);
            model_fill(mode);
        end else begin
            check("fill_ignored_mode", bus.busy, 1'b0);
        end
    endtask

    task automatic do_read(input int addr);
        logic [31:0] exp = model_read(addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'(addr);
        step();
        bus.rd_en = 1'b0;
        check("read_valid", bus.rd_valid, 1'b1);
        check($sformatf("read_data[%0d]", addr), bus.rd_data, exp);
        last_rd = exp;
    endtask

    task automatic do_write(input int addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'(addr);
        bus.wr_data = data;
        step();
        bus.wr_en = 1'b0;
        model_write(addr, data);
    endtask

    task automatic do_dump(input int count);
        int n = (count > DEPTH) ? DEPTH : count;
        bus.dump_start = 1'b1;
        bus.dump_count = 9'(count);
        step();
        bus.dump_start = 1'b0;
        check("dump_lead_busy", bus.busy, 1'b1);
        check("dump_lead_valid", bus.dump_valid, 1'b0);
        check("dump_lead_done", bus.dump_done, 1'b0);
        if (n == 0) begin
            step();
            check("dump0_done", bus.dump_done, 1'b1);
            check("dump0_valid", bus.dump_valid, 1'b0);
        end else begin
            for (int k = 0; k < n; k++) begin
                step();
                check("dump_valid", bus.dump_valid, 1'b1);
                check("dump_addr", bus.dump_addr, 64'(k));
                check($sformatf("dump_data[%0d]", k), bus.dump_data, model[k]);
                check("dump_done", bus.dump_done, (k == n - 1));
                check("dump_busy", bus.busy, 1'b1);
            end
        end
        step();
        check("dump_end_busy", bus.busy, 1'b0);
        check("dump_end_valid", bus.dump_valid, 1'b0);
        check("dump_end_done", bus.dump_done, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        errors  = 0;
        checks  = 0;
        saw_dump = 1'b0;
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // reset state: automatic pattern fill begins
        check("rst_busy", bus.busy, 1'b1);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_data", bus.rd_data, 32'h0);
        check("rst_dump_valid", bus.dump_valid, 1'b0);
        check("rst_dump_done", bus.dump_done, 1'b0);
        check("rst_dump_addr", bus.dump_addr, 8'h0);
        wait_idle("reset_fill_cycles", DEPTH);
        model_fill(1);
        last_rd = 32'h0;

        do_dump(3);

        do_fill(0);
        do_dump(2);
        do_read(199);

        // table of single-cycle port vectors after the constant fill
        vecs[0] = '{1'b1, 8'd5,   32'hdeadbeef, 1'b1, 8'd5,   1'b1, 32'hff223344};
        vecs[1] = '{1'b0, 8'd0,   32'h0,        1'b1, 8'd5,   1'b1, 32'hdeadbeef};
        vecs[2] = '{1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b0, 32'hdeadbeef};
        vecs[3] = '{1'b0, 8'd0,   32'h0,        1'b1, 8'd210, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 8'd210, 32'h12345678, 1'b1, 8'd199, 1'b1, 32'hff223344};
        vecs[5] = '{1'b0, 8'd0,   32'h0,        1'b1, 8'd210, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 8'd199, 32'h0000abcd, 1'b1, 8'd199, 1'b1, 32'hff223344};
        vecs[7] = '{1'b0, 8'd0,   32'h0,        1'b1, 8'd199, 1'b1, 32'h0000abcd};
        vecs[8] = '{1'b1, 8'd0,   32'h00000001, 1'b0, 8'd0,   1'b0, 32'h0000abcd};
        vecs[9] = '{1'b0, 8'd0,   32'h0,        1'b1, 8'd0,   1'b1, 32'h00000001};
        for (int i = 0; i < 10; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_addr = vecs[i].wr_addr;
            bus.wr_data = vecs[i].wr_data;
            bus.rd_en   = vecs[i].rd_en;
            bus.rd_addr = vecs[i].rd_addr;
            step();
            clear_inputs();
            check($sformatf("vec%0d_valid", i), bus.rd_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_data", i), bus.rd_data, vecs[i].exp_data);
            if (vecs[i].wr_en) model_write(int'(vecs[i].wr_addr), vecs[i].wr_data);
            last_rd = vecs[i].exp_data;
        end

        // reset in the middle of a fill restarts the pattern fill from 0
        do_write(150, 32'h1);
        do_read(150);
        bus.init_start = 1'b1;
        bus.init_mode  = 2'd0;
        step();
        bus.init_start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 10) begin
                bus.rd_en = 1'b1;
                bus.rd_addr = 8'd150;
            end
            step();
            if (k == 10) begin
                clear_inputs();
                check("busy_read_ignored", bus.rd_valid, 1'b0);
                check("busy_mid_fill", bus.busy, 1'b1);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", bus.busy, 1'b1);
        check("midrst_rd_valid", bus.rd_valid, 1'b0);
        wait_idle("midrst_fill_cycles", DEPTH);
        model_fill(1);
        last_rd = 32'h0;
        do_read(150);
        check("addr150_pattern", bus.rd_data, 32'hff120096);

        do_dump(0);
        do_dump(255);

        // simultaneous init/dump request: fill wins, no beats; write during fill dropped
        saw_dump = 1'b0;
        bus.init_start = 1'b1;
        bus.init_mode  = 2'd0;
        bus.dump_start = 1'b1;
        bus.dump_count = 9'd5;
        step();
        clear_inputs();
        check("both_busy", bus.busy, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                bus.wr_en = 1'b1;
                bus.wr_addr = 8'd2;
                bus.wr_data = 32'h55;
            end
            if (bus.dump_valid === 1'b1) saw_dump = 1'b1;
            step();
            clear_inputs();
        end
        wait_idle("both_fill_cycles", DEPTH - 20);
        model_fill(0);
        for (int k = 0; k < 3; k++) begin
            if (bus.dump_valid === 1'b1 || bus.dump_done === 1'b1) saw_dump = 1'b1;
            step();
        end
        check("both_no_dump", saw_dump, 1'b0);
        do_read(2);
        do_read(210);

        // randomized port traffic against the array model
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_fill($urandom_range(0, 1));
            end else begin
                logic        we  = 1'($urandom_range(0, 1));
                logic        re  = 1'($urandom_range(0, 1));
                logic [7:0]  wa  = 8'($urandom_range(0, 255));
                logic [7:0]  ra  = 8'($urandom_range(0, 255));
                logic [31:0] wd  = $urandom;
                logic [31:0] exp;
                if ($urandom_range(0, 3) == 0) ra = wa;
                if ($urandom_range(0, 9) == 0) begin
                    bus.init_start = 1'b1;
                    bus.init_mode  = 2'($urandom_range(2, 3));
                end
                bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
                bus.rd_en = re; bus.rd_addr = ra;
                exp = re ? model_read(int'(ra)) : last_rd;
                step();
                clear_inputs();
                check("rand_valid", bus.rd_valid, re);
                check("rand_data", bus.rd_data, exp);
                check("rand_busy", bus.busy, 1'b0);
                last_rd = exp;
                if (we) model_write(int'(wa), wd);
            end
        end
        do_dump(DEPTH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
